// File: rtl/hex_mux_test_amisha.sv
// rtl/hex_mux_test_amisha.sv - four-digit multiplexed seven-segment display of a, b and a+b
// The top two refresh-counter bits pick the active digit; segments are combinational.
module hex_mux_test_amisha #(
  parameter int N = 18
) (
  input  logic       clk_amisha,
  input  logic       reset_amisha,
  input  logic [7:0] sw_amisha,
  output logic [3:0] an_amisha,
  output logic [7:0] sseg_amisha
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;
  logic [1:0]   sel;
  logic [3:0]   op_a;
  logic [3:0]   op_b;
  logic [7:0]   sum;
  logic [3:0]   hex;
  logic         dp;
  logic [6:0]   seg;

  assign q_d = q_q + N'(1);

  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign sel  = q_q[N-1:N-2];
  assign op_a = sw_amisha[3:0];
  assign op_b = sw_amisha[7:4];
  assign sum  = {4'b0000, op_a} + {4'b0000, op_b};

  // Only digit2 lights its decimal point, separating the operands from the sum.
  always_comb begin
    an_amisha = 4'b1110;
    hex       = op_a;
    dp        = 1'b1;
    case (sel)
      2'b00: begin
        an_amisha = 4'b1110;
        hex       = op_a;
      end
      2'b01: begin
        an_amisha = 4'b1101;
        hex       = op_b;
      end
      2'b10: begin
        an_amisha = 4'b1011;
        hex       = sum[3:0];
        dp        = 1'b0;
      end
      default: begin
        an_amisha = 4'b0111;
        hex       = sum[7:4];
      end
    endcase
  end

  always_comb begin
    seg = 7'b1111111;
    case (hex)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
  end

  assign sseg_amisha = {dp, seg};

endmodule

// File: tb/tb_hex_mux_test_amisha.sv
// tb/tb_hex_mux_test_amisha.sv - randomized and directed check of the display multiplexer
// The model tracks clocks since reset and derives digit, anode and glyph arithmetically.
module tb_hex_mux_test_amisha;

  logic       clk_amisha;
  logic       reset_amisha;
  logic [7:0] sw_amisha;
  logic [3:0] an_amisha;
  logic [7:0] sseg_amisha;

  int checks;
  int errors;
  int cnt;
  logic [6:0] seg_tbl [16];
  logic [7:0] dir_sw  [4];
  logic [7:0] dir_exp [4][4];

  hex_mux_test_amisha #(.N(4)) dut (
    .clk_amisha   (clk_amisha),
    .reset_amisha (reset_amisha),
    .sw_amisha    (sw_amisha),
    .an_amisha    (an_amisha),
    .sseg_amisha  (sseg_amisha)
  );

  initial clk_amisha = 1'b0;
  always #5 clk_amisha = ~clk_amisha;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_amisha);
    #1;
    cnt = (cnt + 1) % 16;
  endtask

  task automatic do_reset();
    reset_amisha = 1'b1;
    @(posedge clk_amisha);
    #1;
    reset_amisha = 1'b0;
    cnt = 0;
  endtask

  task automatic check_model(input string tag);
    int digit;
    int a;
    int b;
    int s;
    int val;
    logic [3:0] exp_an;
    digit  = cnt / 4;
    a      = sw_amisha % 16;
    b      = sw_amisha / 16;
    s      = a + b;
    val    = (digit == 0) ? a : (digit == 1) ? b : (digit == 2) ? s % 16 : s / 16;
    exp_an = 4'hF & ~(4'h1 << digit);
    check_eq({tag, "_an"}, {4'h0, an_amisha}, {4'h0, exp_an});
    check_eq({tag, "_sseg"}, sseg_amisha, {(digit != 2), seg_tbl[val]});
    check_eq({tag, "_onehot"}, 8'($countones(~an_amisha)), 8'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cnt    = 0;
    seg_tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    dir_sw  = '{8'h00, 8'hBA, 8'hA2, 8'hDB};
    dir_exp = '{'{8'h81, 8'h81, 8'h01, 8'h81},
                '{8'h88, 8'hE0, 8'h24, 8'hCF},
                '{8'h92, 8'h88, 8'h31, 8'h81},
                '{8'hE0, 8'hC2, 8'h00, 8'hCF}};
    reset_amisha = 1'b1;
    sw_amisha    = 8'h00;
    do_reset();
    check_eq("reset_an", {4'h0, an_amisha}, 8'h0E);
    check_eq("reset_sseg", sseg_amisha, 8'h81);

    // Directed patterns: each digit held for four clocks, then wraps back to digit0.
    for (int p = 0; p < 4; p++) begin
      sw_amisha = dir_sw[p];
      do_reset();
      for (int d = 0; d < 4; d++) begin
        check_eq($sformatf("dir%0d_d%0d", p, d), sseg_amisha, dir_exp[p][d]);
        check_eq($sformatf("dir%0d_an%0d", p, d), {4'h0, an_amisha}, {4'h0, 4'hF & ~(4'h1 << d)});
        for (int k = 0; k < 4; k++) begin
          check_model($sformatf("dir%0d", p));
          tick();
        end
      end
      check_eq($sformatf("dir%0d_wrap", p), {4'h0, an_amisha}, 8'h0E);
    end

    // Random switches, changed twice within a cycle to show zero latency.
    for (int i = 0; i < 300; i++) begin
      sw_amisha = 8'($urandom);
      #1;
      check_model("rnd_a");
      sw_amisha = 8'($urandom);
      #3;
      check_model("rnd_b");
      tick();
      if ($urandom_range(0, 40) == 0) begin
        do_reset();
        check_model("rnd_rst");
      end
    end

    // Mid-scan reset while digit2 is active.
    do_reset();
    while (cnt != 8) tick();
    check_eq("pre_rst_an", {4'h0, an_amisha}, 8'h0B);
    do_reset();
    check_eq("mid_rst_an", {4'h0, an_amisha}, 8'h0E);
    check_model("mid_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_mux_test_amisha.md
HEX_MUX_TEST_AMISHA -- requirements
Module: hex_mux_test_amisha

Interface
REQ-001 Parameter N, default 18, refresh counter width; the top two bits select the active digit.
REQ-002 The module SHALL have exactly one clock and one reset; reset is synchronous and active-high.
REQ-003 clk_amisha  input  1  system clock; all state updates on the rising edge.
REQ-004 reset_amisha  input  1  synchronous active-high reset.
REQ-005 sw_amisha  input  8  switch inputs: operand a = sw_amisha[3:0], operand b = sw_amisha[7:4].
REQ-006 an_amisha  output  4  digit enables, active-low, one-hot-zero; bit i enables digit i.
REQ-007 sseg_amisha  output  8  segments, active-low; bit 7 = dp, bits 6..0 = segments a,b,c,d,e,f,g (bit 6 = a, bit 0 = g).

Function
REQ-008 Sum: sum[7:0] = {4'b0,a} + {4'b0,b}, unsigned, range 0x00-0x1E, no overflow.
REQ-009 Digit sources: digit0 = a; digit1 = b; digit2 = sum[3:0]; digit3 = sum[7:4].
REQ-010 Decimal points: dp pattern 4'b1011 (active-low); only digit2 lights dp (sseg_amisha[7]=0); all other digits drive sseg_amisha[7]=1.
REQ-011 Refresh counter q[N-1:0] increments by 1 every clock and wraps from all-ones to zero.
REQ-012 Digit select sel = q[N-1:N-2]: 00 -> an=1110 / digit0; 01 -> 1101 / digit1; 10 -> 1011 / digit2; 11 -> 0111 / digit3.
REQ-013 Each digit is active for 2^(N-2) consecutive clocks; the full scan period is 2^N clocks.
REQ-014 an_amisha and sseg_amisha are combinational from q and sw_amisha; a switch change appears on sseg_amisha in the same cycle, with no register latency.
REQ-015 Hex-to-segment encoding for sseg_amisha[6:0]:
- 0=0000001, 1=1001111, 2=0010010, 3=0000110
- 4=1001100, 5=0100100, 6=0100000, 7=0001111
- 8=0000000, 9=0000100, A=0001000, b=1100000
- C=0110001, d=1000010, E=0110000, F=0111000
REQ-016 Exactly one an_amisha bit is low at all times after reset; the output never blanks.
REQ-017 sw_amisha is used asynchronously, without synchronizers; glitches during a switch change are acceptable.

Reset
REQ-018 When reset_amisha=1 at a rising edge, q SHALL load 0; the next edge with reset low resumes counting from 0.
REQ-019 While q=0 after reset: an_amisha=1110 and sseg_amisha shows digit0 (operand a) with dp off.
REQ-020 Reset asserted mid-scan SHALL return to digit0 at the next edge, regardless of the current digit.
REQ-021 Before the first reset, output values are undefined; the bench SHALL apply reset first.

Verification (use N=4, so each digit lasts 4 clocks)
REQ-022 Reset, sw=0x00 -> an=1110, sseg=0x81; after 4 clocks an=1101, sseg=0x81; digit2 sseg=0x01; digit3 sseg=0x81.
REQ-023 sw=0xBA (a=A, b=B, sum=0x15) -> digit0 0x88, digit1 0xE0, digit2 0x24, digit3 0xCF.
REQ-024 sw=0xA2 (a=2, b=A, sum=0x0C) -> digit0 0x92, digit1 0x88, digit2 0x31, digit3 0x81.
REQ-025 sw=0xDB (a=B, b=D, sum=0x18) -> digit0 0xE0, digit1 0xC2, digit2 0x00, digit3 0xCF.
REQ-026 Run 16+ clocks -> an sequence 1110,1101,1011,0111 repeats and wraps; assert reset while an=1011 -> an=1110 at the next edge.
REQ-027 Change sw while digit0 is active -> sseg updates in the same cycle; exactly one an bit is low on every cycle.
